// File: rtl/secuenciador_promedio_if.sv
// Sample, averager and result handshakes of the averaging sequencer.
// The master view belongs to the sequencer. The slave view is the environment:
// the sample source, the averager and the result consumer.
interface secuenciador_promedio_if #(
    parameter int N = 8
);
    // Sample source side
    logic          smp_valid;
    logic [15:0]   smp_data;
    logic          smp_ready;

    // Averager side
    logic          avg_en;
    logic          avg_sum_en;
    logic [15:0]   avg_in;
    logic [N-1:0]  avg_out;
    logic          avg_sum_ready;

    // Result consumer side
    logic          res_valid;
    logic [N-1:0]  res_data;
    logic          res_ready;

    modport master (
        input  smp_valid, smp_data, avg_out, avg_sum_ready, res_ready,
        output smp_ready, avg_en, avg_sum_en, avg_in, res_valid, res_data
    );

    modport slave (
        output smp_valid, smp_data, avg_out, avg_sum_ready, res_ready,
        input  smp_ready, avg_en, avg_sum_en, avg_in, res_valid, res_data
    );
endinterface

// File: rtl/secuenciador_promedio.sv
// Sequencer for the 4-sample averager.
// It collects four samples and plays them into one averaging window.
// It then captures the averager result and offers it on a valid/ready port.
// Only one window is in flight at a time. The block runs continuously while en=1.
module secuenciador_promedio #(
    parameter int N       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    secuenciador_promedio_if.master  bus,
    output logic                     err,
    output logic [7:0]               win_count
);

    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FEED,
        ST_WAIT,
        ST_CAPTURE,
        ST_RESULT
    } state_t;

    state_t        state;
    logic [2:0]    cnt;          // samples held in the buffer
    logic [1:0]    idx;          // buffer slot currently on avg_in
    logic [7:0]    tmo;          // WAIT cycles elapsed, including the current one
    logic [15:0]   smp_buf [4];
    logic [N-1:0]  res_q;

    assign bus.res_data = res_q;

    // Sequencer FSM. Every output is a register set on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            cnt            <= '0;
            idx            <= '0;
            tmo            <= '0;
            for (int unsigned i = 0; i < 4; i++) smp_buf[i] <= '0;
            bus.smp_ready  <= 1'b0;
            bus.avg_en     <= 1'b0;
            bus.avg_sum_en <= 1'b0;
            bus.avg_in     <= '0;
            bus.res_valid  <= 1'b0;
            res_q          <= '0;
            err            <= 1'b0;
            win_count      <= '0;
        end else if (!en) begin
            // Abort: drop any partial buffer or unconsumed result, keep err/win_count
            state          <= ST_IDLE;
            cnt            <= '0;
            idx            <= '0;
            tmo            <= '0;
            for (int unsigned i = 0; i < 4; i++) smp_buf[i] <= '0;
            bus.smp_ready  <= 1'b0;
            bus.avg_en     <= 1'b0;
            bus.avg_sum_en <= 1'b0;
            bus.avg_in     <= '0;
            bus.res_valid  <= 1'b0;
        end else begin
            bus.avg_en <= 1'b1;
            case (state)
                ST_IDLE: begin
                    // avg_sum_en was low for this cycle, so the averager is cleared
                    bus.avg_sum_en <= 1'b0;
                    cnt            <= '0;
                    bus.smp_ready  <= 1'b1;
                    state          <= ST_LOAD;
                end

                ST_LOAD: begin
                    if (bus.smp_valid && bus.smp_ready) begin
                        smp_buf[cnt[1:0]] <= bus.smp_data;
                        if (cnt == 3'd3) begin
                            // Fourth sample: slot 0 was written earlier and can go out now
                            cnt            <= 3'd4;
                            bus.smp_ready  <= 1'b0;
                            idx            <= '0;
                            bus.avg_sum_en <= 1'b1;
                            bus.avg_in     <= smp_buf[0];
                            state          <= ST_FEED;
                        end else begin
                            cnt <= cnt + 3'd1;
                        end
                    end
                end

                ST_FEED: begin
                    if (idx == 2'd3) begin
                        bus.avg_in <= '0;
                        tmo        <= 8'd1;
                        state      <= ST_WAIT;
                    end else begin
                        idx        <= idx + 2'd1;
                        bus.avg_in <= smp_buf[idx + 2'd1];
                    end
                end

                ST_WAIT: begin
                    if (bus.avg_sum_ready) begin
                        state <= ST_CAPTURE;
                    end else if (tmo == TMO_LIMIT) begin
                        err            <= 1'b1;
                        cnt            <= '0;
                        for (int unsigned i = 0; i < 4; i++) smp_buf[i] <= '0;
                        bus.avg_sum_en <= 1'b0;
                        state          <= ST_IDLE;
                    end else begin
                        tmo <= tmo + 8'd1;
                    end
                end

                ST_CAPTURE: begin
                    // avg_out settles the cycle after the done pulse, which is this cycle
                    res_q          <= bus.avg_out;
                    bus.res_valid  <= 1'b1;
                    win_count      <= win_count + 8'd1;
                    bus.avg_sum_en <= 1'b0;
                    state          <= ST_RESULT;
                end

                ST_RESULT: begin
                    if (bus.res_ready) begin
                        bus.res_valid <= 1'b0;
                        cnt           <= '0;
                        state         <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_secuenciador_promedio.sv
// Testbench for the averaging sequencer.
// It pairs the block with a behavioural 4-sample averager and drives random and directed windows.
// Each window is compared against a reference average computed from the samples offered.
module tb_secuenciador_promedio;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       en    = 1'b0;
    logic       err;
    logic [7:0] win_count;

    secuenciador_promedio_if #(.N(8)) bus ();

    secuenciador_promedio #(.N(8), .TIMEOUT(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .bus       (bus),
        .err       (err),
        .win_count (win_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_win = 0;
    logic exp_err = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural averager: sums 4 samples into 8 bits and pulses done 2 cycles after the last one.
    // The average appears on avg_out the cycle after the pulse.
    logic [7:0] acc;
    int         acc_cnt;
    logic       done;
    bit         avg_dead = 1'b0;

    always @(posedge clk) begin
        if (reset || bus.avg_sum_en !== 1'b1) begin
            acc     <= '0;
            acc_cnt <= 0;
            done    <= 1'b0;
        end else begin
            acc_cnt <= (acc_cnt < 15) ? acc_cnt + 1 : acc_cnt;
            if (acc_cnt < 4) acc <= acc + bus.avg_in[7:0];
            done <= (acc_cnt == 4) && !avg_dead;
        end
    end

    always @(posedge clk) begin
        if (reset) bus.avg_out <= '0;
        else if (done) bus.avg_out <= acc >> 2;
    end

    assign bus.avg_sum_ready = done;

    // Window monitor: first four avg_in values of each avg_sum_en burst, and the burst length.
    logic [15:0] feed_log [$];
    int          burst = 0;
    int          last_burst = 0;
    bit          prev_en = 1'b0;

    always @(negedge clk) begin
        if (bus.avg_sum_en === 1'b1) begin
            if (!prev_en) begin
                feed_log.delete();
                burst = 0;
            end
            burst++;
            if (feed_log.size() < 4) feed_log.push_back(bus.avg_in);
        end else if (prev_en) begin
            last_burst = burst;
        end
        prev_en = (bus.avg_sum_en === 1'b1);
    end

    task automatic check_all_zero(input string tag);
        check_val({tag, "_smp_ready"},  bus.smp_ready,  0);
        check_val({tag, "_avg_en"},     bus.avg_en,     0);
        check_val({tag, "_avg_sum_en"}, bus.avg_sum_en, 0);
        check_val({tag, "_avg_in"},     bus.avg_in,     0);
        check_val({tag, "_res_valid"},  bus.res_valid,  0);
        check_val({tag, "_res_data"},   bus.res_data,   0);
        check_val({tag, "_err"},        err,            0);
        check_val({tag, "_win_count"},  win_count,      0);
    endtask

    // Offer four samples in order. With toggle set, smp_valid drops for one cycle after each one.
    task automatic feed4(input logic [15:0] s0, s1, s2, s3, input bit toggle);
        logic [15:0] s [4];
        bit ok;
        s = '{s0, s1, s2, s3};
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            ok = 1'b0;
            bus.smp_valid = 1'b1;
            bus.smp_data  = s[i];
            for (int t = 0; t < 200 && !ok; t++) begin
                @(negedge clk);
                if (bus.smp_ready === 1'b1) ok = 1'b1;
            end
            check_val("smp_handshake", ok, 1);
            @(posedge clk); #1;
            if (toggle) begin
                bus.smp_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        bus.smp_valid = 1'b0;
    endtask

    task automatic wait_result(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) ok = 1'b1;
        end
        check_val("res_valid_seen", ok, 1);
    endtask

    // One full window checked against the reference average.
    task automatic do_window(input logic [15:0] s0, s1, s2, s3, input bit toggle, input int hold);
        logic [15:0] s [4];
        int          total;
        logic [7:0]  exp;
        bit          ok;
        s     = '{s0, s1, s2, s3};
        total = int'(s0) + int'(s1) + int'(s2) + int'(s3);
        exp   = 8'((total % 256) / 4);
        bus.res_ready = (hold == 0);
        feed4(s0, s1, s2, s3, toggle);
        wait_result(ok);
        exp_win = (exp_win + 1) % 256;
        check_val("res_data",  bus.res_data, exp);
        check_val("win_count", win_count,    exp_win);
        check_val("err",       err,          exp_err);
        check_val("feed_len",  feed_log.size(), 4);
        for (int i = 0; i < 4; i++)
            if (feed_log.size() > i) check_val($sformatf("avg_in_%0d", i), feed_log[i], s[i]);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_val("hold_valid",     bus.res_valid, 1);
            check_val("hold_data",      bus.res_data,  exp);
            check_val("hold_smp_ready", bus.smp_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(negedge clk);
        check_val("res_valid_drop", bus.res_valid, 0);
        check_val("burst_len",      last_burst,    7);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] r [4];
        int  rv_seen;
        bit  ok;
        bus.smp_valid = 1'b0;
        bus.smp_data  = '0;
        bus.res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b0;
        en    = 1'b1;

        // Directed windows: basic, 8-bit wrap, gapped valid, back-pressure
        do_window(16'd4, 16'd8, 16'd12, 16'd16, 1'b0, 0);
        do_window(16'd100, 16'd100, 16'd100, 16'd100, 1'b0, 0);
        do_window(16'd1, 16'd2, 16'd3, 16'd6, 1'b1, 0);
        do_window(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 20);

        // Random windows
        for (int w = 0; w < 12; w++) begin
            for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
            do_window(r[0], r[1], r[2], r[3], 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        // Averager never answers: timeout after 16 WAIT cycles, then back to LOAD
        avg_dead = 1'b1;
        bus.res_ready = 1'b1;
        feed4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        @(negedge clk);
        check_val("tmo_err_pre", err, 0);
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.avg_sum_en === 1'b0) ok = 1'b1;
        end
        check_val("tmo_end_seen",  ok,            1);
        check_val("tmo_err",       err,           1);
        check_val("tmo_win_count", win_count,     exp_win);
        check_val("tmo_res_valid", bus.res_valid, 0);
        check_val("tmo_smp_ready", bus.smp_ready, 0);
        @(negedge clk);
        check_val("tmo_burst_len", last_burst,    20);
        check_val("tmo_reload",    bus.smp_ready, 1);
        exp_err  = 1'b1;
        avg_dead = 1'b0;

        // Abort on the third FEED cycle
        for (int i = 0; i < 4; i++) r[i] = 16'($urandom);
        feed4(r[0], r[1], r[2], r[3], 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        en = 1'b0;
        @(negedge clk);
        check_val("abort_feed_en",  bus.avg_sum_en, 1);
        check_val("abort_feed_idx", bus.avg_in,     r[2]);
        @(negedge clk);
        check_val("abort_sum_en",    bus.avg_sum_en, 0);
        check_val("abort_smp_ready", bus.smp_ready,  0);
        rv_seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (bus.res_valid === 1'b1) rv_seen++;
        end
        check_val("abort_no_result", rv_seen,   0);
        check_val("abort_win_count", win_count, exp_win);
        check_val("abort_err_kept",  err,       1);
        @(posedge clk); #1;
        en = 1'b1;
        do_window(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0, 0);

        // Reset while a result is pending
        bus.res_ready = 1'b0;
        feed4(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        wait_result(ok);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        reset   = 1'b0;
        exp_win = 0;
        exp_err = 1'b0;
        do_window(16'd40, 16'd0, 16'd0, 16'd0, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
